// File: rtl/multi_voice_phase_accumulator.sv
// Time-multiplexed multi-voice NCO: one shared adder sweeps all voices per sample tick,
// producing saw/square/triangle/inverted-saw samples with hard sync and wrap flags.
module multi_voice_phase_accumulator #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 11,
  parameter int VOICES = 8,
  localparam int VIDX_W = $clog2(VOICES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_tick,
  input  logic              cfg_wr_en,
  input  logic [VIDX_W-1:0] cfg_voice,
  input  logic [ACC_W-1:0]  cfg_tw,
  input  logic [1:0]        cfg_mode,
  input  logic [OUT_W-1:0]  pulse_width,
  input  logic [VOICES-1:0] sync_req,
  output logic [OUT_W-1:0]  wave_out,
  output logic [VIDX_W-1:0] wave_voice,
  output logic              wave_valid,
  output logic              wave_wrap,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [VIDX_W-1:0] LAST = VIDX_W'(VOICES - 1);

  state_t             state;
  logic [VIDX_W-1:0]  v;
  logic [ACC_W-1:0]   phase [VOICES];
  logic [ACC_W-1:0]   tw    [VOICES];
  logic [1:0]         mode  [VOICES];
  logic [VOICES-1:0]  pending;

  logic               sync_now;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   new_phase;
  logic               new_wrap;
  logic [OUT_W-1:0]   p;
  logic [OUT_W-1:0]   wave_next;

  // A sync request arriving in the voice's own update cycle is honoured immediately.
  always_comb begin
    sync_now  = pending[v] | sync_req[v];
    sum       = {1'b0, phase[v]} + {1'b0, tw[v]};
    new_phase = sync_now ? '0 : sum[ACC_W-1:0];
    new_wrap  = sync_now ? 1'b0 : sum[ACC_W];
    p         = new_phase[ACC_W-1 -: OUT_W];
    case (mode[v])
      2'd0:    wave_next = p;
      2'd1:    wave_next = (p < pulse_width) ? '1 : '0;
      2'd2:    wave_next = {p[OUT_W-2:0], 1'b0} ^ {OUT_W{p[OUT_W-1]}};
      default: wave_next = ~p;
    endcase
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      v          <= '0;
      pending    <= '0;
      wave_out   <= '0;
      wave_voice <= '0;
      wave_valid <= 1'b0;
      wave_wrap  <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        phase[i] <= '0;
        tw[i]    <= '0;
        mode[i]  <= '0;
      end
    end else begin
      wave_valid <= 1'b0;
      pending    <= pending | sync_req;
      if (cfg_wr_en && (32'(cfg_voice) < VOICES)) begin
        tw[cfg_voice]   <= cfg_tw;
        mode[cfg_voice] <= cfg_mode;
      end
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= RUN;
            v     <= '0;
          end
        end
        RUN: begin
          if (sample_tick) overrun <= 1'b1;
          // Clearing the voice's pending bit here overrides the OR-accumulate above.
          phase[v]   <= new_phase;
          pending[v] <= 1'b0;
          wave_out   <= wave_next;
          wave_voice <= v;
          wave_wrap  <= new_wrap;
          wave_valid <= 1'b1;
          if (v == LAST) state <= IDLE;
          else           v     <= v + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
